// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the hazard/stall controller.
// Holds the FSM state encoding and the hard-wired zero register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        FLUSH_PEND = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-to-hazard-unit signal bundle.
// The master side is the pipeline datapath; the slave side is the hazard unit.
interface hazard_stall_unit_if;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        ID_use_rs1;
    logic        ID_use_rs2;
    logic [4:0]  EX_rd;
    logic        EX_memread;
    logic        branch_taken;
    logic        im_stall;
    logic        dm_stall;

    logic        stall_PC;
    logic        stall_IFID;
    logic        stall_IDEX;
    logic        stall_EXMEM;
    logic        stall_MEMWB;
    logic        flush_IFID;
    logic        flush_IDEX;
    logic        HazardMuxControl;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_flush_cnt;

    modport master (
        output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_memread,
               branch_taken, im_stall, dm_stall,
        input  stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, stall_MEMWB,
               flush_IFID, flush_IDEX, HazardMuxControl,
               perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_memread,
               branch_taken, im_stall, dm_stall,
        output stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, stall_MEMWB,
               flush_IFID, flush_IDEX, HazardMuxControl,
               perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/hazard_stall_unit_perf_cnt.sv
// Free-running, wrapping performance counters for stall, bubble and flush cycles.
// Only instantiated when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_busy,
    input  logic        bubble,
    input  logic        flush,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt,
    output logic [31:0] flush_cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (mem_busy) stall_cnt  <= stall_cnt + 32'd1;
            if (bubble)   bubble_cnt <= bubble_cnt + 32'd1;
            if (flush)    flush_cnt  <= flush_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: memory freeze, load-use bubble, and branch flush
// that is deferred until a pending memory stall releases. Optional counters: HAZARD_PERF_CNT_EN.
//
// state      | meaning
// RUN        | no memory stall outstanding, no deferred flush
// MEM_WAIT   | memory stall in progress, no branch seen during it
// FLUSH_PEND | branch taken while frozen; flush owed on release
module hazard_stall_unit
    import hazard_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    hazard_stall_unit_if.slave hz
);

    hz_state_t state, state_nxt;
    logic      mem_busy;
    logic      load_use;
    logic      stall_all;
    logic      bubble;
    logic      flush;

    assign mem_busy = hz.im_stall | hz.dm_stall;
    assign load_use = hz.EX_memread && (hz.EX_rd != REG_X0) &&
                      ((hz.ID_use_rs1 && (hz.EX_rd == hz.ID_rs1)) ||
                       (hz.ID_use_rs2 && (hz.EX_rd == hz.ID_rs2)));

    always_comb begin
        stall_all = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        state_nxt = state;
        if (mem_busy) begin
            stall_all = 1'b1;
            state_nxt = (hz.branch_taken || state == FLUSH_PEND) ? FLUSH_PEND : MEM_WAIT;
        end else begin
            state_nxt = RUN;
            if (hz.branch_taken || state == FLUSH_PEND) flush  = 1'b1;
            else if (load_use)                          bubble = 1'b1;
        end
        // reset forces idle outputs combinationally, independent of inputs
        if (!rst) begin
            stall_all = 1'b0;
            bubble    = 1'b0;
            flush     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end

    assign hz.stall_PC         = stall_all | bubble;
    assign hz.stall_IFID       = stall_all | bubble;
    assign hz.stall_IDEX       = stall_all;
    assign hz.stall_EXMEM      = stall_all;
    assign hz.stall_MEMWB      = stall_all;
    assign hz.flush_IFID       = flush;
    assign hz.flush_IDEX       = flush;
    assign hz.HazardMuxControl = ~bubble;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .mem_busy   (stall_all),
        .bubble     (bubble),
        .flush      (flush),
        .stall_cnt  (hz.perf_stall_cnt),
        .bubble_cnt (hz.perf_bubble_cnt),
        .flush_cnt  (hz.perf_flush_cnt)
    );
`else
    assign hz.perf_stall_cnt  = '0;
    assign hz.perf_bubble_cnt = '0;
    assign hz.perf_flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed plus randomized bench for hazard_stall_unit against a pending-flush reference model.
// Works in both builds; counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_stall_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    hazard_stall_unit_if hif ();

    hazard_stall_unit dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.slave)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // reference model: one "flush owed" bit plus three counters
    bit          m_pending;
    logic [31:0] m_stall, m_bubble, m_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef HAZARD_PERF_CNT_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    // packed control {stall_PC,IFID,IDEX,EXMEM,MEMWB,flush_IFID,flush_IDEX,HMC}
    localparam logic [7:0] C_IDLE   = 8'b00000_00_1;
    localparam logic [7:0] C_STALL  = 8'b11111_00_1;
    localparam logic [7:0] C_FLUSH  = 8'b00000_11_1;
    localparam logic [7:0] C_BUBBLE = 8'b11000_00_0;

    task automatic step(input logic r, input logic im, input logic dm, input logic br,
                        input logic memrd, input logic [4:0] exrd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input string tag);
        logic       busy, lu;
        logic [7:0] exp, obs;
        @(negedge clk);
        rst              = r;
        hif.im_stall     = im;
        hif.dm_stall     = dm;
        hif.branch_taken = br;
        hif.EX_memread   = memrd;
        hif.EX_rd        = exrd;
        hif.ID_rs1       = rs1;
        hif.ID_rs2       = rs2;
        hif.ID_use_rs1   = u1;
        hif.ID_use_rs2   = u2;
        #1;
        if (!r) m_pending = 1'b0;
        busy = im | dm;
        lu   = memrd && exrd != 5'd0 && ((u1 && exrd == rs1) || (u2 && exrd == rs2));
        if (!r)                    exp = C_IDLE;
        else if (busy)             exp = C_STALL;
        else if (m_pending || br)  exp = C_FLUSH;
        else if (lu)               exp = C_BUBBLE;
        else                       exp = C_IDLE;
        if (!r) begin
            m_stall = 0; m_bubble = 0; m_flush = 0;
        end
        obs = {hif.stall_PC, hif.stall_IFID, hif.stall_IDEX, hif.stall_EXMEM, hif.stall_MEMWB,
               hif.flush_IFID, hif.flush_IDEX, hif.HazardMuxControl};
        chk({tag, ".ctl"}, {24'd0, obs}, {24'd0, exp});
        chk({tag, ".stall_cnt"},  hif.perf_stall_cnt,  cnt_exp(m_stall));
        chk({tag, ".bubble_cnt"}, hif.perf_bubble_cnt, cnt_exp(m_bubble));
        chk({tag, ".flush_cnt"},  hif.perf_flush_cnt,  cnt_exp(m_flush));
        // advance model to the upcoming rising edge
        if (r) begin
            if (busy) begin
                m_stall++;
                m_pending = m_pending | br;
            end else begin
                m_pending = 1'b0;
            end
            if (exp == C_FLUSH)  m_flush++;
            if (exp == C_BUBBLE) m_bubble++;
        end
    endtask

    task automatic idle(input string tag);
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, tag);
    endtask

    logic [31:0] snap;

    initial begin
        hif.im_stall = 0; hif.dm_stall = 0; hif.branch_taken = 0; hif.EX_memread = 0;
        hif.EX_rd = 0; hif.ID_rs1 = 0; hif.ID_rs2 = 0; hif.ID_use_rs1 = 0; hif.ID_use_rs2 = 0;
        m_pending = 0; m_stall = 0; m_bubble = 0; m_flush = 0;

        // reset forces idle regardless of inputs
        step(0, 1, 1, 1, 1, 5'd5, 5'd5, 5'd5, 1, 1, "rst_busy");
        step(0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd5, 1, 1, "rst_lu");
        idle("post_rst");

        // load-use on x5, then load advances
        step(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 1, 0, "lu_rs1");
        step(1, 0, 0, 0, 0, 5'd5, 5'd5, 5'd1, 1, 0, "lu_clear");
        step(1, 0, 0, 0, 1, 5'd7, 5'd2, 5'd7, 0, 1, "lu_rs2");
        step(1, 0, 0, 0, 1, 5'd7, 5'd7, 5'd7, 0, 0, "lu_unused");
        step(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, "lu_x0");

        // branch flush in RUN
        step(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "br_run");
        idle("br_after");

        // dm_stall for exactly 4 cycles
        snap = hif.perf_stall_cnt;
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0, "dm_stall");
        step(1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0, "dm_release_lu");
        chk("dm_stall_delta", hif.perf_stall_cnt - snap, cnt_exp(32'd4));

        // branch during im_stall, deferred flush on release only
        snap = hif.perf_flush_cnt;
        step(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "im_br");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 5'd4, 5'd4, 5'd0, 1, 0, "im_hold");
        step(1, 0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 1, 0, "im_release");
        idle("im_after");
        chk("im_flush_delta", hif.perf_flush_cnt - snap, cnt_exp(32'd1));

        // flush beats load-use
        step(1, 0, 0, 1, 1, 5'd9, 5'd9, 5'd9, 1, 1, "br_and_lu");
        idle("br_lu_after");

        // reset while in FLUSH_PEND discards the flush
        step(1, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "fp_enter");
        step(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "fp_hold");
        step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "fp_rst");
        chk("fp_rst_cnt_zero", hif.perf_stall_cnt | hif.perf_flush_cnt | hif.perf_bubble_cnt, 32'd0);
        idle("fp_rst_release");
        idle("fp_no_flush");

        // randomized traffic with bursty memory stalls
        begin
            int busy_left = 0;
            for (int n = 0; n < 2000; n++) begin
                logic im, dm, r;
                if (busy_left == 0 && $urandom_range(0, 9) < 2) busy_left = $urandom_range(1, 6);
                im = 0; dm = 0;
                if (busy_left > 0) begin
                    if ($urandom_range(0, 1) == 1) im = 1; else dm = 1;
                    if ($urandom_range(0, 3) == 0) begin im = 1; dm = 1; end
                    busy_left--;
                end
                r = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
                step(r, im, dm, ($urandom_range(0, 99) < 15),
                     $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
